// File: rtl/falling_object_tracker_if.sv
// Spawn/paddle inputs and renderer/HUD outputs of the falling object tracker.
// The master side is the game logic driving spawns; the slave side is the tracker.
interface falling_object_tracker_if;
  logic [10:0] object_position;
  logic [10:0] player_x;
  logic        pause;
  logic [3:0]  obj_valid;
  logic [43:0] obj_x;
  logic [39:0] obj_y;
  logic [15:0] score;
  logic [3:0]  lives;
  logic        game_over;
  logic        catch_pulse;
  logic        miss_pulse;
  logic [7:0]  dropped_count;

  modport master (
    output object_position, player_x, pause,
    input  obj_valid, obj_x, obj_y, score, lives, game_over,
           catch_pulse, miss_pulse, dropped_count
  );
  modport slave (
    input  object_position, player_x, pause,
    output obj_valid, obj_x, obj_y, score, lives, game_over,
           catch_pulse, miss_pulse, dropped_count
  );
endinterface

// File: rtl/falling_object_tracker.sv
// Four-slot falling object pool: latches spawns, moves objects on a divided
// tick and scores each one against the paddle when it reaches the catch line.
module falling_object_slot #(
  parameter int OBJ_WIDTH    = 32,
  parameter int PLAYER_WIDTH = 64,
  parameter int Y_START      = 0,
  parameter int CATCH_Y      = 440,
  parameter int STEP_PX      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        spawn,
  input  logic        tick,
  input  logic [10:0] spawn_x,
  input  logic [10:0] player_x,
  output logic        valid,
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic        caught,
  output logic        missed
);
  logic        valid_q, valid_d;
  logic [10:0] x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic [10:0] y_new;
  logic        land, overlap;

  always_comb begin
    y_new   = {1'b0, y_q} + 11'(STEP_PX);
    overlap = (({1'b0, x_q} + 12'(OBJ_WIDTH)) > {1'b0, player_x}) &&
              ({1'b0, x_q} < ({1'b0, player_x} + 12'(PLAYER_WIDTH)));
    land    = tick && valid_q && (y_new >= 11'(CATCH_Y));
    valid_d = valid_q;
    x_d     = x_q;
    y_d     = y_q;
    if (tick && valid_q) begin
      if (land) valid_d = 1'b0;
      else      y_d     = y_new[9:0];
    end
    // Spawn only targets a slot that was free before this cycle's tick.
    if (spawn) begin
      valid_d = 1'b1;
      x_d     = spawn_x;
      y_d     = 10'(Y_START);
    end
    if (clear) valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      valid_q <= valid_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  assign valid  = valid_q;
  assign x      = x_q;
  assign y      = y_q;
  assign caught = land && overlap;
  assign missed = land && !overlap;
endmodule

module falling_object_tracker #(
  parameter int UNDEFINED_POSITION = 1000,
  parameter int X_MAX              = 600,
  parameter int OBJ_WIDTH          = 32,
  parameter int PLAYER_WIDTH       = 64,
  parameter int Y_START            = 0,
  parameter int CATCH_Y            = 440,
  parameter int STEP_DIV           = 500000,
  parameter int STEP_PX            = 2,
  parameter int INIT_LIVES         = 3
) (
  input logic clk,
  input logic rst,
  falling_object_tracker_if.slave bus
);
  localparam int NUM_LANES = 4;
  localparam int DIV_W     = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  typedef enum logic {PLAY, GAME_OVER} state_t;

  state_t                         state_q, state_d;
  logic [10:0]                    prev_q;
  logic [DIV_W-1:0]               div_q, div_d;
  logic [15:0]                    score_q, score_d;
  logic [3:0]                     lives_q, lives_d;
  logic [7:0]                     drop_q, drop_d;
  logic                           catch_pulse_q, catch_pulse_d;
  logic                           miss_pulse_q, miss_pulse_d;

  logic [NUM_LANES-1:0]           valid, caught, missed, free, grant, spawn_vec;
  logic [NUM_LANES-1:0][10:0]     xs;
  logic [NUM_LANES-1:0][9:0]      ys;
  logic                           active, tick, spawn_ev, spawn_ok, go_over;
  logic [10:0]                    spawn_x;
  logic [2:0]                     n_catch, n_miss;
  logic [16:0]                    score_sum;

  always_comb begin
    active    = (state_q == PLAY) && !bus.pause;
    tick      = active && (div_q == DIV_W'(STEP_DIV - 1));
    div_d     = !active ? div_q : (tick ? '0 : div_q + DIV_W'(1));
    spawn_ev  = (bus.object_position != 11'(UNDEFINED_POSITION)) &&
                (bus.object_position != prev_q);
    spawn_ok  = spawn_ev && active;
    spawn_x   = (bus.object_position > 11'(X_MAX)) ? 11'(X_MAX) : bus.object_position;
    // Lowest-index free slot, judged on occupancy before this cycle's tick.
    free      = ~valid;
    grant     = free & (~free + 4'd1);
    spawn_vec = spawn_ok ? grant : '0;

    n_catch = '0;
    n_miss  = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      n_catch = n_catch + {2'b0, caught[i]};
      n_miss  = n_miss  + {2'b0, missed[i]};
    end

    score_sum = {1'b0, score_q} + 17'(n_catch);
    score_d   = score_sum[16] ? 16'hFFFF : score_sum[15:0];
    lives_d   = (lives_q > {1'b0, n_miss}) ? lives_q - {1'b0, n_miss} : 4'd0;
    drop_d    = drop_q;
    if (spawn_ok && (free == '0) && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;

    go_over       = (state_q == PLAY) && (lives_d == 4'd0);
    state_d       = go_over ? GAME_OVER : state_q;
    catch_pulse_d = |caught;
    miss_pulse_d  = |missed;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= PLAY;
      prev_q        <= 11'(UNDEFINED_POSITION);
      div_q         <= '0;
      score_q       <= '0;
      lives_q       <= 4'(INIT_LIVES);
      drop_q        <= '0;
      catch_pulse_q <= 1'b0;
      miss_pulse_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      prev_q        <= bus.object_position;
      div_q         <= div_d;
      score_q       <= score_d;
      lives_q       <= lives_d;
      drop_q        <= drop_d;
      catch_pulse_q <= catch_pulse_d;
      miss_pulse_q  <= miss_pulse_d;
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_slot
    falling_object_slot #(
      .OBJ_WIDTH   (OBJ_WIDTH),
      .PLAYER_WIDTH(PLAYER_WIDTH),
      .Y_START     (Y_START),
      .CATCH_Y     (CATCH_Y),
      .STEP_PX     (STEP_PX)
    ) u_slot (
      .clk     (clk),
      .rst     (rst),
      .clear   (go_over),
      .spawn   (spawn_vec[g]),
      .tick    (tick),
      .spawn_x (spawn_x),
      .player_x(bus.player_x),
      .valid   (valid[g]),
      .x       (xs[g]),
      .y       (ys[g]),
      .caught  (caught[g]),
      .missed  (missed[g])
    );
  end

  assign bus.obj_valid     = valid;
  assign bus.obj_x         = xs;
  assign bus.obj_y         = ys;
  assign bus.score         = score_q;
  assign bus.lives         = lives_q;
  assign bus.game_over     = (state_q == GAME_OVER);
  assign bus.catch_pulse   = catch_pulse_q;
  assign bus.miss_pulse    = miss_pulse_q;
  assign bus.dropped_count = drop_q;
endmodule

// File: tb/tb_falling_object_tracker.sv
// Directed bench for falling_object_tracker with a short divider (4 cycles
// per tick, 2 px per tick, catch line at 8), so each object lands on its 4th tick.
module tb_falling_object_tracker;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  falling_object_tracker_if bus ();

  falling_object_tracker #(
    .STEP_DIV(4),
    .STEP_PX (2),
    .CATCH_Y (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic         rst;
    logic         pause;
    logic [10:0]  pos;
    logic [10:0]  px;
    logic [127:0] exp;
    string        name;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [127:0] pk(logic [3:0] v, logic [43:0] x, logic [39:0] y,
                                      logic [15:0] s, logic [3:0] l, logic g, logic c,
                                      logic m, logic [7:0] d);
    return {9'd0, v, x, y, s, l, g, c, m, d};
  endfunction

  function automatic logic [127:0] obs();
    return pk(bus.obj_valid, bus.obj_x, bus.obj_y, bus.score, bus.lives,
              bus.game_over, bus.catch_pulse, bus.miss_pulse, bus.dropped_count);
  endfunction

  task automatic add(logic r, logic p, logic [10:0] pos, logic [10:0] px,
                     logic [127:0] e, string nm);
    vec_t v;
    v.rst = r; v.pause = p; v.pos = pos; v.px = px; v.exp = e; v.name = nm;
    tbl.push_back(v);
  endtask

  task automatic go(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.object_position = 11'd1000;
    go(1);
    rst = 1'b0;
  endtask

  localparam logic [127:0] RST_VEC = {9'd0, 4'd0, 44'd0, 40'd0, 16'd0, 4'd3, 3'b000, 8'd0};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    bus.object_position = 11'd1000;
    bus.player_x        = 11'd100;
    bus.pause           = 1'b0;

    // Single spawn at x=120 falls four ticks and is caught by paddle at 100.
    add(1, 0, 1000, 100, pk(0, 0, 0, 0, 3, 0, 0, 0, 0), "A_reset");
    add(0, 0, 120,  100, pk(1, 120, 0, 0, 3, 0, 0, 0, 0), "A_spawn");
    add(0, 0, 120,  100, pk(1, 120, 0, 0, 3, 0, 0, 0, 0), "A_hold");
    add(0, 0, 1000, 100, pk(1, 120, 0, 0, 3, 0, 0, 0, 0), "A_e3");
    add(0, 0, 1000, 100, pk(1, 120, 2, 0, 3, 0, 0, 0, 0), "A_tick1");
    repeat (3) add(0, 0, 1000, 100, pk(1, 120, 2, 0, 3, 0, 0, 0, 0), "A_y2");
    add(0, 0, 1000, 100, pk(1, 120, 4, 0, 3, 0, 0, 0, 0), "A_tick2");
    repeat (3) add(0, 0, 1000, 100, pk(1, 120, 4, 0, 3, 0, 0, 0, 0), "A_y4");
    add(0, 0, 1000, 100, pk(1, 120, 6, 0, 3, 0, 0, 0, 0), "A_tick3");
    repeat (3) add(0, 0, 1000, 100, pk(1, 120, 6, 0, 3, 0, 0, 0, 0), "A_y6");
    add(0, 0, 1000, 100, pk(0, 120, 6, 1, 3, 0, 1, 0, 0), "A_catch");
    add(0, 0, 1000, 100, pk(0, 120, 6, 1, 3, 0, 0, 0, 0), "A_pulse_end");
    // Clamp, undefined value, held value, and pause holding divider and spawns.
    add(1, 0, 1000, 100, pk(0, 0, 0, 0, 3, 0, 0, 0, 0), "B_reset");
    add(0, 0, 900,  100, pk(1, 600, 0, 0, 3, 0, 0, 0, 0), "B_clamp");
    add(0, 0, 1000, 100, pk(1, 600, 0, 0, 3, 0, 0, 0, 0), "B_undef");
    add(0, 0, 200,  100, pk(3, {22'd0, 11'd200, 11'd600}, 0, 0, 3, 0, 0, 0, 0), "B_spawn2");
    add(0, 0, 200,  100, pk(3, {22'd0, 11'd200, 11'd600}, {20'd0, 10'd2, 10'd2}, 0, 3, 0, 0, 0, 0), "B_tick");
    repeat (3)
      add(0, 0, 200, 100, pk(3, {22'd0, 11'd200, 11'd600}, {20'd0, 10'd2, 10'd2}, 0, 3, 0, 0, 0, 0), "B_held");
    add(0, 1, 300,  100, pk(3, {22'd0, 11'd200, 11'd600}, {20'd0, 10'd2, 10'd2}, 0, 3, 0, 0, 0, 0), "B_pause");
    add(0, 0, 300,  100, pk(3, {22'd0, 11'd200, 11'd600}, {20'd0, 10'd4, 10'd4}, 0, 3, 0, 0, 0, 0), "B_resume");

    for (int i = 0; i < tbl.size(); i++) begin
      rst                 = tbl[i].rst;
      bus.pause           = tbl[i].pause;
      bus.object_position = tbl[i].pos;
      bus.player_x        = tbl[i].px;
      go(1);
      chk(tbl[i].name, obs(), tbl[i].exp);
    end
    bus.pause = 1'b0;

    // Three misses drain lives and enter game over.
    do_reset();
    bus.player_x = 11'd300;
    bus.object_position = 11'd120; go(1);
    bus.object_position = 11'd1000; go(15);
    chk("miss1_lives", 128'(bus.lives), 128'd2);
    chk("miss1_pulse", 128'({bus.miss_pulse, bus.catch_pulse, bus.obj_valid}), 128'(6'b10_0000));
    bus.object_position = 11'd121; go(1);
    bus.object_position = 11'd1000; go(15);
    chk("miss2_lives", 128'(bus.lives), 128'd1);
    bus.object_position = 11'd122; go(1);
    bus.object_position = 11'd1000; go(15);
    chk("gameover_entry", 128'({bus.lives, bus.game_over, bus.obj_valid, bus.miss_pulse}), 128'({4'd0, 1'b1, 4'd0, 1'b1}));
    bus.object_position = 11'd130; go(1);
    chk("gameover_spawn", 128'({bus.obj_valid, bus.dropped_count, bus.game_over}), 128'({4'd0, 8'd0, 1'b1}));
    go(8);
    chk("gameover_stuck", 128'({bus.game_over, bus.score, bus.miss_pulse}), 128'({1'b1, 16'd0, 1'b0}));

    // Full pool drops a spawn, including one that coincides with a landing.
    do_reset();
    bus.player_x = 11'd0;
    bus.object_position = 11'd10; go(1);
    bus.object_position = 11'd20; go(1);
    bus.object_position = 11'd30; go(1);
    bus.object_position = 11'd40; go(1);
    bus.object_position = 11'd50; go(1);
    chk("pool_full", 128'({bus.obj_valid, bus.dropped_count}), 128'({4'b1111, 8'd1}));
    bus.object_position = 11'd1000; go(10);
    bus.object_position = 11'd60; go(1);
    chk("land_and_drop", 128'({bus.obj_valid, bus.dropped_count, bus.score, bus.catch_pulse}),
        128'({4'b1000, 8'd2, 16'd3, 1'b1}));
    bus.object_position = 11'd1000; go(1);
    chk("no_refill", 128'(bus.obj_valid), 128'(4'b1000));
    bus.object_position = 11'd70; go(1);
    chk("refill", 128'({bus.obj_valid, bus.obj_x[10:0]}), 128'({4'b1001, 11'd70}));

    // Simultaneous catch and miss, then reset mid-fall.
    do_reset();
    bus.player_x = 11'd100;
    bus.object_position = 11'd120; go(1);
    bus.object_position = 11'd400; go(1);
    bus.object_position = 11'd1000; go(14);
    chk("catch_and_miss", 128'({bus.score, bus.lives, bus.catch_pulse, bus.miss_pulse, bus.obj_valid}),
        128'({16'd1, 4'd2, 1'b1, 1'b1, 4'd0}));
    bus.object_position = 11'd200; go(1);
    bus.object_position = 11'd1000; go(4);
    chk("mid_fall", 128'({bus.obj_valid, bus.obj_y[9:0]}), 128'({4'b0001, 10'd2}));
    rst = 1'b1;
    bus.object_position = 11'd300; go(1);
    chk("reset_mid_fall", obs(), RST_VEC);
    rst = 1'b0;
    bus.object_position = 11'd1000; go(1);
    chk("reset_spawn_lost", 128'(bus.obj_valid), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
